avalon_pio_in_ctrl: RTL

- Parametrised Avalon-MM slave input port for panel switches and keys in the vending-machine SOPC.
- Signal path per channel: in_port → N-stage synchroniser → optional debouncer → rise/fall edge selection → sticky capture → IRQ.
- Generalises the fixed 18-bit rising-edge PIO. Adds:
  - configurable width;
  - per-bit edge polarity;
  - write-1-to-clear capture;
  - a raw readback register.

---
 rtl/avalon_pio_in_ctrl_if.sv | 28 ++
 rtl/avalon_pio_in_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/avalon_pio_in_ctrl_if.sv
// Avalon-MM slave bus bundle for the PIO input controller.
// The slave modport is used by the controller and the master modport by its bus master.
interface avalon_pio_in_ctrl_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  chipselect,
    input  address,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );

  modport master (
    output chipselect,
    output address,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );
endinterface

// File: rtl/avalon_pio_in_ctrl.sv
// Avalon-MM PIO input port: sync -> optional debounce -> edge select -> sticky capture -> IRQ.
// Define PIO_IN_DEBOUNCE_EN to build the per-bit debouncer and the DB_LIMIT register.
module avalon_pio_in_ctrl #(
  parameter int unsigned      WIDTH       = 18,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [CNT_W-1:0] DB_DEFAULT  = CNT_W'(50000)
) (
  input logic                 clk,
  input logic                 reset_n,
  avalon_pio_in_ctrl_if.slave bus,
  input logic [WIDTH-1:0]     in_port
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  logic [CNT_W-1:0] db_limit_q, db_limit_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;

  // A new limit applies at once; a counter already past it wraps around before matching.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (raw[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == db_limit_q) begin
        stable_d[i] = raw[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    db_limit_d = db_limit_q;
    if (wr && bus.address == 3'd6) db_limit_d = bus.writedata[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q   <= '0;
      db_limit_q <= DB_DEFAULT;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else begin
      stable_q   <= stable_d;
      db_limit_q <= db_limit_d;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stable = stable_q;
`else
  logic [CNT_W-1:0] unused_db_default;

  assign unused_db_default = DB_DEFAULT;
  assign stable            = raw;
`endif

  assign ev  = (rise_en_q & stable & ~stable_dly_q) | (fall_en_q & ~stable & stable_dly_q);
  assign w1c = (wr && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // OR-ing the event after the clear lets a same-cycle event win over W1C.
  always_comb begin
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    cap_d      = (cap_q & ~w1c) | ev;
    if (wr) begin
      case (bus.address)
        3'd2:    irq_mask_d = bus.writedata[WIDTH-1:0];
        3'd4:    rise_en_d  = bus.writedata[WIDTH-1:0];
        3'd5:    fall_en_d  = bus.writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      3'd0:    readdata_d[WIDTH-1:0] = stable;
      3'd1:    readdata_d[WIDTH-1:0] = raw;
      3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      3'd3:    readdata_d[WIDTH-1:0] = cap_q;
      3'd4:    readdata_d[WIDTH-1:0] = rise_en_q;
      3'd5:    readdata_d[WIDTH-1:0] = fall_en_q;
`ifdef PIO_IN_DEBOUNCE_EN
      3'd6:    readdata_d[CNT_W-1:0] = db_limit_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= '0;
      irq_mask_q   <= '0;
      rise_en_q    <= '1;
      fall_en_q    <= '0;
      cap_q        <= '0;
      readdata_q   <= '0;
    end else begin
      stable_dly_q <= stable;
      irq_mask_q   <= irq_mask_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      cap_q        <= cap_d;
      readdata_q   <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(cap_q & irq_mask_q);

endmodule
